// File: rtl/conv3x3_row_engine_if.sv
// Beat/result bundle between the line-buffer feeder, the 3x3 row engine and the feature-map writer.
// The engine takes the slave view; the feeder/writer side takes the master view.
interface conv3x3_row_engine_if #(
  parameter int LANES   = 8,
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [(LANES+2)*DATA_W-1:0]   img_r1;
  logic [(LANES+2)*DATA_W-1:0]   img_r2;
  logic [(LANES+2)*DATA_W-1:0]   img_r3;
  logic [9*COEF_W-1:0]           filter;
  logic signed [ACC_W-1:0]       bias;
  logic [SHIFT_W-1:0]            shift;
  logic [1:0]                    act_mode;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*OUT_W-1:0]        out_data;

  modport master (
    output in_valid, in_last, img_r1, img_r2, img_r3, filter, bias, shift, act_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, img_r1, img_r2, img_r3, filter, bias, shift, act_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv3x3_row_engine.sv
// Pipelined 3x3 convolution over LANES adjacent windows, accumulated across input channels,
// then bias, arithmetic shift, activation and saturation to OUT_W.
module conv3x3_row_engine #(
  parameter int LANES   = 8,
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  conv3x3_row_engine_if.slave  bus
);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] pix,
                                                  input logic signed [COEF_W-1:0] coef);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] c;
    p = PROD_W'($signed({1'b0, pix}));
    c = PROD_W'(coef);
    return p * c;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] y);
    if (y > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (y < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return y[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] post_process(input logic signed [ACC_W-1:0] acc,
                                                          input logic signed [ACC_W-1:0] bias,
                                                          input logic [SHIFT_W-1:0]      shift,
                                                          input logic [1:0]              mode);
    logic signed [ACC_W-1:0] y;
    y = acc + bias;
    y = y >>> shift;
    // Mode 3 falls through as identity.
    if (y < 0) begin
      if (mode == 2'd1)      y = '0;
      else if (mode == 2'd2) y = y >>> 3;
    end
    return saturate(y);
  endfunction

  logic en;
  logic signed [PROD_W-1:0] prod_c  [LANES][9];
  logic signed [PROD_W-1:0] prod_p0 [LANES][9];
  logic                     vld_p0, last_p0;
  logic signed [ACC_W-1:0]  bias_p0;
  logic [SHIFT_W-1:0]       shift_p0;
  logic [1:0]               mode_p0;
  logic signed [ACC_W-1:0]  sum_c  [LANES];
  logic signed [ACC_W-1:0]  sum_p1 [LANES];
  logic                     vld_p1, last_p1;
  logic signed [ACC_W-1:0]  bias_p1;
  logic [SHIFT_W-1:0]       shift_p1;
  logic [1:0]               mode_p1;
  logic signed [ACC_W-1:0]  acc_p2 [LANES];
  logic                     vld_p2, first_p2;
  logic signed [ACC_W-1:0]  bias_p2;
  logic [SHIFT_W-1:0]       shift_p2;
  logic [1:0]               mode_p2;
  logic [LANES*OUT_W-1:0]   out_c;

  assign en          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < 3; c++) begin
        prod_c[l][c]   = mul(bus.img_r1[(LANES+1-l-c)*DATA_W +: DATA_W], bus.filter[(8-c)*COEF_W +: COEF_W]);
        prod_c[l][3+c] = mul(bus.img_r2[(LANES+1-l-c)*DATA_W +: DATA_W], bus.filter[(5-c)*COEF_W +: COEF_W]);
        prod_c[l][6+c] = mul(bus.img_r3[(LANES+1-l-c)*DATA_W +: DATA_W], bus.filter[(2-c)*COEF_W +: COEF_W]);
      end
    end
  end

  // Stage p0: products, beat flags and the config of last beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      bias_p0  <= '0;
      shift_p0 <= '0;
      mode_p0  <= '0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < 9; k++) prod_p0[l][k] <= '0;
    end else if (en) begin
      vld_p0  <= bus.in_valid;
      last_p0 <= bus.in_last;
      prod_p0 <= prod_c;
      if (bus.in_valid && bus.in_last) begin
        bias_p0  <= bus.bias;
        shift_p0 <= bus.shift;
        mode_p0  <= bus.act_mode;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_c[l] = '0;
      for (int k = 0; k < 9; k++) sum_c[l] = sum_c[l] + ACC_W'(prod_p0[l][k]);
    end
  end

  // Stage p1: per-lane window sums, kept off the accumulate path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      bias_p1  <= '0;
      shift_p1 <= '0;
      mode_p1  <= '0;
      for (int l = 0; l < LANES; l++) sum_p1[l] <= '0;
    end else if (en) begin
      vld_p1   <= vld_p0;
      last_p1  <= last_p0;
      sum_p1   <= sum_c;
      bias_p1  <= bias_p0;
      shift_p1 <= shift_p0;
      mode_p1  <= mode_p0;
    end
  end

  // Stage p2: channel accumulation; first restarts the sum after every last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      first_p2 <= 1'b1;
      bias_p2  <= '0;
      shift_p2 <= '0;
      mode_p2  <= '0;
      for (int l = 0; l < LANES; l++) acc_p2[l] <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1 && last_p1;
      if (vld_p1) begin
        for (int l = 0; l < LANES; l++) acc_p2[l] <= (first_p2 ? '0 : acc_p2[l]) + sum_p1[l];
        first_p2 <= last_p1;
      end
      if (vld_p1 && last_p1) begin
        bias_p2  <= bias_p1;
        shift_p2 <= shift_p1;
        mode_p2  <= mode_p1;
      end
    end
  end

  always_comb begin
    out_c = '0;
    for (int l = 0; l < LANES; l++)
      out_c[(LANES-1-l)*OUT_W +: OUT_W] = post_process(acc_p2[l], bias_p2, shift_p2, mode_p2);
  end

  // Output stage: result register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (en) begin
      bus.out_valid <= vld_p2;
      if (vld_p2) bus.out_data <= out_c;
    end
  end
endmodule

// File: tb/tb_conv3x3_row_engine.sv
// Bench for conv3x3_row_engine: fixed vector table, hand-written multi-cycle sequences,
// and randomized beats scored against an arithmetic model of the convolution.
module tb_conv3x3_row_engine;
  typedef struct packed {
    logic [79:0]  r1;
    logic [79:0]  r2;
    logic [79:0]  r3;
    logic [71:0]  filt;
    logic [7:0]   nchan;
    logic [31:0]  bias;
    logic [4:0]   shift;
    logic [1:0]   mode;
    logic [127:0] expv;
  } vec_t;

  logic clk;
  logic rst_n;
  conv3x3_row_engine_if bus ();

  conv3x3_row_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           errors, checks;
  bit           sb_on, hold_chk, acc_seen, rdy_seen, m_first;
  logic [127:0] held;
  int           pix [3][10];
  int           cf [9];
  int           m_acc [8];
  logic [127:0] exp_q [$];
  int           n_out, n_exp;
  vec_t         vt [13];

  function automatic logic [79:0] row_all(input int v);
    logic [79:0] r;
    for (int c = 0; c < 10; c++) r[(9-c)*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [79:0] row_ramp();
    logic [79:0] r;
    for (int c = 0; c < 10; c++) r[(9-c)*8 +: 8] = 8'(c);
    return r;
  endfunction

  function automatic logic [71:0] coef_all(input int v);
    logic [71:0] f;
    for (int k = 0; k < 9; k++) f[(8-k)*8 +: 8] = 8'(v);
    return f;
  endfunction

  function automatic logic [71:0] coef_ctr(input int v);
    logic [71:0] f;
    f = '0;
    f[(8-4)*8 +: 8] = 8'(v);
    return f;
  endfunction

  function automatic logic [127:0] out_all(input int v);
    logic [127:0] o;
    for (int i = 0; i < 8; i++) o[(7-i)*16 +: 16] = 16'(v);
    return o;
  endfunction

  function automatic logic [127:0] out_ramp();
    logic [127:0] o;
    for (int i = 0; i < 8; i++) o[(7-i)*16 +: 16] = 16'(i + 1);
    return o;
  endfunction

  function automatic vec_t mkv(input logic [79:0] r1, input logic [79:0] r2, input logic [79:0] r3,
                               input logic [71:0] f, input int n, input int b, input int sh,
                               input int md, input logic [127:0] e);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.r3 = r3; v.filt = f;
    v.nchan = 8'(n); v.bias = 32'(b); v.shift = 5'(sh); v.mode = 2'(md); v.expv = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one accepted beat: plain window arithmetic over the bench's own pixel/coef arrays.
  task automatic model_accept();
    int s, t, y;
    logic [127:0] e;
    e = '0;
    for (int l = 0; l < 8; l++) begin
      s = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) s += pix[r][l+c] * cf[r*3+c];
      m_acc[l] = (m_first ? 0 : m_acc[l]) + s;
      if (bus.in_last) begin
        t = m_acc[l] + bus.bias;
        y = t >>> bus.shift;
        if (y < 0 && bus.act_mode == 2'd1) y = 0;
        else if (y < 0 && bus.act_mode == 2'd2) y = y >>> 3;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        e[(7-l)*16 +: 16] = 16'(y);
      end
    end
    m_first = bus.in_last;
    if (bus.in_last) exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    acc_seen = bus.in_valid && bus.in_ready;
    rdy_seen = bus.in_ready;
    if (sb_on) begin
      if (hold_chk) chk("hold_stable", {bus.out_valid, bus.out_data}, {1'b1, held});
      hold_chk = bus.out_valid && !bus.out_ready;
      held     = bus.out_data;
      if (acc_seen) model_accept();
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_result: got %0h expected no result", bus.out_data);
        end else begin
          chk("result", bus.out_data, exp_q.pop_front());
          n_out++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pack_cur();
    for (int c = 0; c < 10; c++) begin
      bus.img_r1[(9-c)*8 +: 8] = 8'(pix[0][c]);
      bus.img_r2[(9-c)*8 +: 8] = 8'(pix[1][c]);
      bus.img_r3[(9-c)*8 +: 8] = 8'(pix[2][c]);
    end
    for (int k = 0; k < 9; k++) bus.filter[(8-k)*8 +: 8] = 8'(cf[k]);
  endtask

  task automatic drive(input logic [79:0] r1, input logic [79:0] r2, input logic [79:0] r3,
                       input logic [71:0] f, input bit last, input int b, input int sh, input int md);
    bus.in_valid = 1'b1; bus.in_last = last;
    bus.img_r1 = r1; bus.img_r2 = r2; bus.img_r3 = r3; bus.filter = f;
    bus.bias = 32'(b); bus.shift = 5'(sh); bus.act_mode = 2'(md);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 16) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1 within 16 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold_chk = 1'b0;
    m_first = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    logic [4:0]   seen;
    logic [127:0] d;
    bit           early, stuck;
    int           b, c, n;

    errors = 0; checks = 0; sb_on = 0; n_out = 0; n_exp = 0;
    bus.in_valid = 0; bus.in_last = 0; bus.img_r1 = '0; bus.img_r2 = '0; bus.img_r3 = '0;
    bus.filter = '0; bus.bias = '0; bus.shift = '0; bus.act_mode = '0; bus.out_ready = 1'b1;
    do_reset();

    vt[0]  = mkv(row_all(1), row_all(1), row_all(1), coef_all(1), 1, 0, 0, 0, out_all(9));
    vt[1]  = mkv(row_all(200), row_ramp(), row_all(200), coef_ctr(1), 1, 0, 0, 0, out_ramp());
    vt[2]  = mkv(row_all(8), row_all(8), row_all(8), coef_ctr(-8), 1, 0, 0, 1, out_all(0));
    vt[3]  = mkv(row_all(8), row_all(8), row_all(8), coef_ctr(-8), 1, 0, 0, 2, out_all(-8));
    vt[4]  = mkv(row_all(8), row_all(8), row_all(8), coef_ctr(-8), 1, 0, 0, 0, out_all(-64));
    vt[5]  = mkv(row_all(8), row_all(8), row_all(8), coef_ctr(-8), 1, 0, 0, 3, out_all(-64));
    vt[6]  = mkv(row_all(5), row_all(5), row_all(5), coef_ctr(-13), 1, 0, 0, 2, out_all(-9));
    vt[7]  = mkv(row_all(255), row_all(255), row_all(255), coef_all(127), 4, 0, 0, 0, out_all(32767));
    vt[8]  = mkv(row_all(255), row_all(255), row_all(255), coef_all(-128), 4, 0, 0, 0, out_all(-32768));
    vt[9]  = mkv(row_all(1), row_all(1), row_all(1), coef_all(1), 1, 5, 1, 0, out_all(7));
    vt[10] = mkv(row_all(1), row_all(1), row_all(1), coef_all(1), 1, -20, 0, 1, out_all(0));
    vt[11] = mkv(row_all(255), row_all(255), row_all(255), coef_all(127), 1, 0, 4, 0, out_all(18216));
    vt[12] = mkv(row_all(255), row_all(255), row_all(255), coef_all(-128), 1, 0, 5, 0, out_all(-9180));

    #12;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single last beat: valid exactly one cycle, three edges after acceptance.
    drive(row_all(1), row_all(1), row_all(1), coef_all(1), 1, 0, 0, 0);
    tick();
    bus.in_valid = 0;
    seen = '0; d = '0;
    for (int j = 0; j < 5; j++) begin
      seen[4-j] = bus.out_valid;
      if (j == 3) d = bus.out_data;
      tick();
    end
    chk("latency_valid_pattern", seen, 5'b00010);
    chk("latency_data", d, out_all(9));

    for (int i = 0; i < 13; i++) begin
      for (int ch = 0; ch < int'(vt[i].nchan); ch++) begin
        drive(vt[i].r1, vt[i].r2, vt[i].r3, vt[i].filt, ch == int'(vt[i].nchan) - 1,
              int'(vt[i].bias), int'(vt[i].shift), int'(vt[i].mode));
        tick();
      end
      bus.in_valid = 0;
      wait_out($sformatf("table%0d", i));
      if (bus.out_valid) chk($sformatf("table%0d", i), bus.out_data, vt[i].expv);
      tick();
    end

    // Three channels, config on non-last beats must be ignored.
    early = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (ch < 2) drive(row_all(1), row_all(1), row_all(1), coef_all(ch + 1), 0, 1000, 7, 1);
      else        drive(row_all(1), row_all(1), row_all(1), coef_all(ch + 1), 1, 5, 1, 0);
      tick();
      early |= bus.out_valid;
    end
    bus.in_valid = 0;
    chk("3ch_no_early_valid", early, 0);
    wait_out("3ch");
    if (bus.out_valid) chk("3ch_result", bus.out_data, out_all(29));
    tick();

    // Backpressure: five stalled cycles while six beats stream in.
    sb_on = 1; n_out = 0; b = 0; c = 0;
    for (int k = 0; k < 9; k++) cf[k] = 1;
    while (b < 6 && c < 40) begin
      bus.out_ready = !(c >= 4 && c < 9);
      for (int r = 0; r < 3; r++)
        for (int x = 0; x < 10; x++) pix[r][x] = b + 1;
      pack_cur();
      bus.in_valid = 1; bus.in_last = 1; bus.bias = '0; bus.shift = '0; bus.act_mode = '0;
      tick();
      if (c >= 4 && c < 9) chk($sformatf("bp_in_ready_c%0d", c), rdy_seen, 0);
      if (acc_seen) b++;
      c++;
    end
    bus.in_valid = 0; bus.out_ready = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin tick(); n++; end
    chk("bp_result_count", n_out, 6);
    tick();
    sb_on = 0;

    // Reset between channel beats discards the partial sum.
    drive(row_all(1), row_all(1), row_all(1), coef_all(1), 0, 0, 0, 0);
    tick();
    bus.in_valid = 0;
    tick(); tick();
    do_reset();
    #2;
    chk("midreset_out_valid", bus.out_valid, 0);
    tick();
    rst_n = 1'b1;
    drive(row_all(1), row_all(1), row_all(1), coef_all(1), 1, 0, 0, 0);
    tick();
    bus.in_valid = 0;
    wait_out("midreset");
    if (bus.out_valid) chk("midreset_result", bus.out_data, out_all(9));
    tick();

    // Randomized beats, bubbles and backpressure against the model.
    sb_on = 1; n_out = 0; n_exp = 0; stuck = 0;
    for (int beat = 0; beat < 300 && !stuck; beat++) begin
      for (int r = 0; r < 3; r++)
        for (int x = 0; x < 10; x++) pix[r][x] = int'($urandom_range(0, 255));
      for (int k = 0; k < 9; k++) cf[k] = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 0;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      pack_cur();
      bus.in_valid = 1;
      bus.in_last  = ($urandom_range(0, 2) == 0) || (beat == 299);
      bus.bias     = 32'(int'($urandom_range(0, 2097152)) - 1048576);
      bus.shift    = 5'($urandom_range(0, 12));
      bus.act_mode = 2'($urandom_range(0, 3));
      if (bus.in_last) n_exp++;
      n = 0;
      do begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end while (!acc_seen && n < 50);
      if (!acc_seen) begin
        stuck = 1;
        checks++;
        errors++;
        $display("FAIL rnd_accept_timeout: got in_ready=0 expected acceptance within 50 cycles");
      end
    end
    bus.in_valid = 0; bus.out_ready = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin tick(); n++; end
    chk("rnd_result_count", n_out, n_exp);
    tick();
    chk("rnd_idle_out_valid", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv3x3_row_engine.md
Name: conv3x3_row_engine

Overview:
- Parametrised, pipelined 3x3 convolution row engine; next generation of the fixed 8-lane conv row block.
- Consumes three image rows per beat and produces LANES adjacent outputs.
- Accumulates over multiple input channels, then applies bias, shift, activation and saturation.
- Sits between the line-buffer feeder and the feature-map writer in the CBS (conv-BN-SiLU) path.

Parameters:
LANES, 8, output pixels per beat; row bus carries LANES+2 pixels
DATA_W, 8, unsigned pixel width
COEF_W, 8, signed coefficient width
ACC_W, 32, signed accumulator width
OUT_W, 16, signed output width
SHIFT_W, 5, width of the right-shift field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts a beat this cycle
in_last  in  1  beat is the last input channel for this output row segment
img_r1  in  (LANES+2)*DATA_W  top row; column 0 at MSBs
img_r2  in  (LANES+2)*DATA_W  middle row
img_r3  in  (LANES+2)*DATA_W  bottom row
filter  in  9*COEF_W  coef k=r*3+c at bits [(9-k)*COEF_W-1 -: COEF_W]
bias  in  ACC_W  signed bias; sampled on the accepted in_last beat
shift  in  SHIFT_W  arithmetic right-shift amount; sampled with bias
act_mode  in  2  0 none, 1 ReLU, 2 leaky (x>>>3), 3 treated as 0; sampled with bias
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  LANES*OUT_W  lane 0 at MSBs

Behaviour:
- Single clock. Asynchronous active-low reset clears:
  - all pipeline registers and accumulators;
  - out_valid=0 and out_data=0.
- Reset mid-accumulation discards the partial sums. The first beat after reset starts a fresh accumulation.
- Window for lane i: columns i..i+2 of each row. This matches the legacy block: lane 0 uses the MSB-most 3 pixels.
- Pixels are zero-extended. Coefficients are signed. Each product is signed with width DATA_W+COEF_W+1.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. All pipeline stages advance only when en.
- A beat is accepted when in_valid && in_ready.
- Pipeline, all stages gated by en:
  - S1: register the 9*LANES products, together with valid, last and the sampled config.
  - S2: sum the 9 products per lane, sign-extended to ACC_W. acc <= (first ? 0 : acc) + sum. first is an internal flag: set at reset and after every last beat. Pass last and config.
  - S3: on last, compute y = (acc + bias) >>> shift (arithmetic, ACC_W).
    - Apply the activation: ReLU maps y<0 to 0; leaky maps y<0 to y>>>3.
    - Saturate to signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Register into out_data and set out_valid=1.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+3, when there is no backpressure.
- Throughput: one beat per cycle.
- Non-last beats never assert out_valid.
- Handshake:
  - out_data and out_valid stay stable while out_valid && !out_ready.
  - out_valid clears after acceptance unless a new result arrives on the same edge.
  - A result and acceptance on the same edge: the new result replaces the old one and out_valid stays 1.
- Accumulator overflow beyond ACC_W wraps modulo 2^ACC_W. Sizing is the caller's responsibility.
- in_valid low inserts bubbles and does not disturb the accumulation.
- The internal first flag is only cleared by an accepted beat.
- Config inputs are ignored on non-last beats.

Test Plan:
- All pixels 1, all coefs 1, one beat with in_last=1, bias 0, shift 0, mode 0 -> after 3 cycles every lane = 9, out_valid one cycle (out_ready=1).
- img_r2 columns = 0..9, only centre coef = 1, all else 0 -> lane i = i+1; r1/r3 values have no effect.
- Three-channel accumulation: beats with all-ones pixels and coefs 1, 2, 3, in_last on the third, bias 5, shift 1 -> (9+18+27+5)>>>1 = 29 per lane; no output on the first two beats.
- Activation: accumulated sum -64, bias 0:
  - mode 1 -> 0;
  - mode 2 -> -8;
  - mode 0 -> -64.
- Saturation: pixels 255, coefs 127, 4 last-terminated channels, shift 0 -> acc 1165860 -> every lane 32767. Repeat with coefs -128 -> -32768.
- Backpressure: hold out_ready=0 for 5 cycles while streaming beats ->
  - in_ready=0 for those cycles and out_data stable;
  - after release, every result appears in order with no loss or duplication.
- Reset asserted between two channel beats, then one last beat of all-ones -> output 9, not the stale partial sum.
